accel_spi_slave: RTL and testbench

ACCEL_SPI_SLAVE -- requirements
Module: accel_spi_slave

---
 rtl/accel_spi_slave_if.sv | 33 +++
 rtl/accel_spi_slave.sv | 252 +++++++++++++++++++++++++
 tb/tb_accel_spi_slave.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_spi_slave_if.sv
// ============================================================================
// Module      : accel_spi_slave_if
// Description : SPI bus bundle (mode 0) between a master and the accelerometer
//               register slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface accel_spi_slave_if;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output sclk,
        output cs,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sclk,
        input  cs,
        input  mosi,
        output miso,
        output miso_oe
    );
endinterface

`default_nettype wire

// File: rtl/accel_spi_slave.sv
// ============================================================================
// Module      : accel_spi_slave
// Description : Mode-0 SPI register slave for an accelerometer, oversampled by
//               clk. Macro ACCEL_AUTOINC_EN enables address auto-increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEV_ID      = 8'hAD
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    accel_spi_slave_if.slave      spi,
    input  wire logic [7:0]       x_data,
    input  wire logic [7:0]       y_data,
    input  wire logic [7:0]       z_data,
    output logic                  meas_mode,
    output logic                  soft_rst
);

    localparam logic [7:0] c_cmd_write  = 8'h0A;
    localparam logic [7:0] c_cmd_read   = 8'h0B;
    localparam logic [7:0] c_srst_addr  = 8'h1F;
    localparam logic [7:0] c_srst_key   = 8'h52;
    localparam logic [3:0] c_power_ctl  = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

    // Reset: asserted asynchronously, released synchronously to clk
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic cs_prev_q,   cs_prev_d;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [7:0]  addr_q, addr_d;
    logic        is_read_q, is_read_d;
    logic        miso_q, miso_d;
    logic        miso_oe_q, miso_oe_d;
    logic        soft_rst_q, soft_rst_d;
    logic [7:0]  x_snap_q, x_snap_d;
    logic [7:0]  y_snap_q, y_snap_d;
    logic [7:0]  z_snap_q, z_snap_d;
    logic [15:0][7:0] rw_regs_q, rw_regs_d;

    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_fall;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [7:0] addr_inc;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_sh_q, mosi_s};

`ifdef ACCEL_AUTOINC_EN
    assign addr_inc = addr_q + 8'd1;
`else
    assign addr_inc = addr_q;
`endif

    // Address of the byte to preload: the new address while in ADDR,
    // otherwise the address the next DATA byte will use
    assign rd_addr = (state_q == ST_ADDR) ? rx_byte : addr_inc;

    always_comb begin
        rd_data = 8'h00;
        if (rd_addr[7:4] == 4'h2) begin
            rd_data = rw_regs_q[rd_addr[3:0]];
        end else begin
            case (rd_addr)
                8'h00:   rd_data = DEV_ID;
                8'h01:   rd_data = 8'h1D;
                8'h02:   rd_data = 8'hF2;
                8'h08:   rd_data = x_snap_q;
                8'h09:   rd_data = y_snap_q;
                8'h0A:   rd_data = z_snap_q;
                default: rd_data = 8'h00;
            endcase
        end
    end

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi.cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        addr_d     = addr_q;
        is_read_d  = is_read_q;
        miso_d     = 1'b0;
        miso_oe_d  = ~cs_s;
        soft_rst_d = 1'b0;
        x_snap_d   = x_snap_q;
        y_snap_d   = y_snap_q;
        z_snap_d   = z_snap_q;
        rw_regs_d  = rw_regs_q;

        if (sclk_rise) begin
            rx_sh_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (cs_s) begin
            // Deselect aborts everything; a partial byte is simply dropped
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = 3'd0;
                    if (cs_fall) begin
                        state_d  = ST_CMD;
                        x_snap_d = x_data;
                        y_snap_d = y_data;
                        z_snap_d = z_data;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        if (rx_byte == c_cmd_write) begin
                            state_d   = ST_ADDR;
                            is_read_d = 1'b0;
                        end else if (rx_byte == c_cmd_read) begin
                            state_d   = ST_ADDR;
                            is_read_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        state_d = ST_DATA;
                        addr_d  = rx_byte;
                        tx_sh_d = rd_data;
                    end
                end
                ST_DATA: begin
                    if (is_read_q) begin
                        miso_d = miso_q;
                        if (sclk_fall) begin
                            miso_d  = tx_sh_q[7];
                            tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        end
                        if (byte_done) begin
                            addr_d  = addr_inc;
                            tx_sh_d = rd_data;
                        end
                    end else if (byte_done) begin
                        addr_d = addr_inc;
                        if (addr_q[7:4] == 4'h2) begin
                            rw_regs_d[addr_q[3:0]] = rx_byte;
                        end else if ((addr_q == c_srst_addr) && (rx_byte == c_srst_key)) begin
                            soft_rst_d = 1'b1;
                            rw_regs_d  = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_sh_q     <= 7'd0;
            tx_sh_q     <= 8'd0;
            addr_q      <= 8'd0;
            is_read_q   <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            soft_rst_q  <= 1'b0;
            x_snap_q    <= 8'd0;
            y_snap_q    <= 8'd0;
            z_snap_q    <= 8'd0;
            rw_regs_q   <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            addr_q      <= addr_d;
            is_read_q   <= is_read_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            soft_rst_q  <= soft_rst_d;
            x_snap_q    <= x_snap_d;
            y_snap_q    <= y_snap_d;
            z_snap_q    <= z_snap_d;
            rw_regs_q   <= rw_regs_d;
        end
    end

    assign spi.miso    = miso_q;
    assign spi.miso_oe = miso_oe_q;
    assign soft_rst    = soft_rst_q;
    assign meas_mode   = (rw_regs_q[c_power_ctl][1:0] == 2'b10);

endmodule

`default_nettype wire

// File: tb/tb_accel_spi_slave.sv
// ============================================================================
// Module      : tb_accel_spi_slave
// Description : Directed self-checking bench for accel_spi_slave (mode-0 SPI
//               master bit-banged from tasks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_spi_slave;

    localparam int c_half = 100;

    logic       clk;
    logic       rst_n;
    logic [7:0] x_data, y_data, z_data;
    logic       meas_mode;
    logic       soft_rst;

    int n_checks = 0;
    int n_fail   = 0;
    int sr_count = 0;
    logic oe_low_seen;
    logic miso_seen;

    accel_spi_slave_if spi_if ();

    accel_spi_slave #(
        .SYNC_STAGES (2),
        .DEV_ID      (8'hAD)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (spi_if),
        .x_data    (x_data),
        .y_data    (y_data),
        .z_data    (z_data),
        .meas_mode (meas_mode),
        .soft_rst  (soft_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (soft_rst) sr_count <= sr_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_if.mosi = b;
        #(c_half);
        r = spi_if.miso;
        if (spi_if.miso_oe !== 1'b1) oe_low_seen = 1'b1;
        if (spi_if.miso !== 1'b0) miso_seen = 1'b1;
        spi_if.sclk = 1'b1;
        #(c_half);
        spi_if.sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_start();
        oe_low_seen  = 1'b0;
        miso_seen    = 1'b0;
        spi_if.cs    = 1'b0;
        #(c_half);
    endtask

    task automatic cs_end();
        #(c_half);
        spi_if.cs   = 1'b1;
        spi_if.mosi = 1'b0;
        #(2 * c_half);
    endtask

    task automatic spi_write(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] rx;
        cs_start();
        spi_byte(8'h0A, rx);
        spi_byte(addr, rx);
        spi_byte(data, rx);
        cs_end();
    endtask

    task automatic spi_read(input logic [7:0] addr, output logic [7:0] data);
        logic [7:0] rx;
        cs_start();
        spi_byte(8'h0B, rx);
        spi_byte(addr, rx);
        spi_byte(8'hFF, data);
        cs_end();
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] b0, b1, b2;
        logic       r;

        rst_n       = 1'b0;
        spi_if.cs   = 1'b1;
        spi_if.sclk = 1'b0;
        spi_if.mosi = 1'b0;
        x_data      = 8'h00;
        y_data      = 8'h00;
        z_data      = 8'h00;
        #20;
        check("rst_miso",      32'(spi_if.miso),    32'h0);
        check("rst_miso_oe",   32'(spi_if.miso_oe), 32'h0);
        check("rst_meas_mode", 32'(meas_mode),      32'h0);
        check("rst_soft_rst",  32'(soft_rst),       32'h0);
        #30;
        rst_n = 1'b1;
        #100;

        // Device ID read, output enable tracks chip select
        spi_read(8'h00, rd);
        check("devid", 32'(rd), 32'hAD);
        check("devid_oe_during", 32'(oe_low_seen), 32'h0);
        check("devid_oe_after", 32'(spi_if.miso_oe), 32'h0);
        spi_read(8'h01, rd);
        check("id1", 32'(rd), 32'h1D);
        spi_read(8'h02, rd);
        check("id2", 32'(rd), 32'hF2);

        // sclk activity with cs high must not disturb anything
        for (int i = 0; i < 8; i++) begin
            spi_if.mosi = i[0];
            #(c_half); spi_if.sclk = 1'b1;
            #(c_half); spi_if.sclk = 1'b0;
        end
        spi_read(8'h00, rd);
        check("idle_sclk_ignored", 32'(rd), 32'hAD);

        // POWER_CTL write and readback
        spi_write(8'h2D, 8'h02);
        check("meas_mode_set", 32'(meas_mode), 32'h1);
        spi_read(8'h2D, rd);
        check("power_ctl_rb", 32'(rd), 32'h02);
        spi_write(8'h25, 8'hA5);
        spi_read(8'h25, rd);
        check("reg25_rb", 32'(rd), 32'hA5);
        spi_write(8'h30, 8'h77);
        spi_read(8'h30, rd);
        check("reg30_unmapped", 32'(rd), 32'h00);

        // Coherent sample burst with x_data changing mid-burst
        x_data = 8'h11; y_data = 8'h22; z_data = 8'h33;
        #100;
        cs_start();
        spi_byte(8'h0B, rd);
        spi_byte(8'h08, rd);
        spi_byte(8'hFF, b0);
        x_data = 8'h99;
        spi_byte(8'hFF, b1);
        spi_byte(8'hFF, b2);
        cs_end();
        check("burst_b0", 32'(b0), 32'h11);
`ifdef ACCEL_AUTOINC_EN
        check("burst_b1", 32'(b1), 32'h22);
        check("burst_b2", 32'(b2), 32'h33);
`else
        check("burst_b1", 32'(b1), 32'h11);
        check("burst_b2", 32'(b2), 32'h11);
`endif

        // Address wrap from 0xFF
        cs_start();
        spi_byte(8'h0B, rd);
        spi_byte(8'hFF, rd);
        spi_byte(8'hFF, b0);
        spi_byte(8'hFF, b1);
        cs_end();
        check("wrap_b0", 32'(b0), 32'h00);
`ifdef ACCEL_AUTOINC_EN
        check("wrap_b1", 32'(b1), 32'hAD);
`else
        check("wrap_b1", 32'(b1), 32'h00);
`endif

        // Soft reset
        sr_count = 0;
        spi_write(8'h1F, 8'h52);
        check("soft_rst_pulses", 32'(sr_count), 32'd1);
        check("soft_rst_meas", 32'(meas_mode), 32'h0);
        spi_read(8'h2D, rd);
        check("soft_rst_2d", 32'(rd), 32'h00);
        spi_read(8'h25, rd);
        check("soft_rst_25", 32'(rd), 32'h00);
        spi_read(8'h1F, rd);
        check("reg1f_reads0", 32'(rd), 32'h00);

        // Partial byte aborted by cs rising
        spi_write(8'h2D, 8'h02);
        cs_start();
        spi_byte(8'h0A, rd);
        spi_byte(8'h2D, rd);
        for (int i = 7; i >= 4; i--) spi_bit(i == 1, r);
        cs_end();
        check("partial_oe", 32'(spi_if.miso_oe), 32'h0);
        check("partial_meas", 32'(meas_mode), 32'h1);
        spi_read(8'h2D, rd);
        check("partial_rb", 32'(rd), 32'h02);

        // Unknown command: miso quiet, nothing written
        cs_start();
        spi_byte(8'h5A, rd);
        spi_byte(8'h2D, rd);
        spi_byte(8'h00, rd);
        spi_byte(8'h0B, rd);
        cs_end();
        check("badcmd_miso", 32'(miso_seen), 32'h0);
        spi_read(8'h2D, rd);
        check("badcmd_rb", 32'(rd), 32'h02);

        // Reset asserted mid-transfer
        cs_start();
        spi_byte(8'h0A, rd);
        spi_byte(8'h2D, rd);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
        rst_n = 1'b0;
        #20;
        check("midrst_oe", 32'(spi_if.miso_oe), 32'h0);
        check("midrst_meas", 32'(meas_mode), 32'h0);
        spi_if.cs   = 1'b1;
        spi_if.mosi = 1'b0;
        #40;
        rst_n = 1'b1;
        #100;
        spi_read(8'h2D, rd);
        check("midrst_rb", 32'(rd), 32'h00);
        spi_read(8'h00, rd);
        check("midrst_devid", 32'(rd), 32'hAD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
